// File: rtl/kernel_config_ctrl.sv
// Kernel/divisor/invert configuration for the 3x3 convolution datapath.
// Presets or user-entered coefficients go to a pending set, applied to the outputs at frame start.
module kernel_config_ctrl #(
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned CW         = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      filter,
  input  logic [CW-1:0]   k_in,
  input  logic            store,
  input  logic            div,
  input  logic            frame_start,
  output logic [9*CW-1:0] k_flat,
  output logic [6:0]      divide,
  output logic            invert,
  output logic [8:0]      led_store,
  output logic            led_display,
  output logic            busy
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  // One hex nibble per coefficient, k0 in the low nibble.
  function automatic logic [9*CW-1:0] kpack(input logic [35:0] nib);
    logic [9*CW-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < 9; j++) r[j*CW +: CW] = CW'(nib[j*4 +: 4]);
    return r;
  endfunction

  localparam logic [9*CW-1:0] K_ID = kpack(36'h000010000);
  localparam logic [9*CW-1:0] K_BL = kpack(36'h121242121);
  localparam logic [9*CW-1:0] K_BR = kpack(36'h000030000);

  typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

  state_t           state;
  logic [3:0]       idx;
  logic [9*CW-1:0]  k_custom;
  logic [9*CW-1:0]  pend_k;
  logic [6:0]       pend_div;
  logic             pend_inv;

  logic             sync1, sync2, deb;
  logic [CNT_W-1:0] deb_cnt;
  logic             store_evt;

  logic [9*CW-1:0]  preset_k;
  logic [6:0]       preset_div;
  logic             preset_inv;
  logic [6:0]       sum;

  // Button conditioning: 2-flop sync, stable-count debounce, pulse on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb       <= 1'b0;
      deb_cnt   <= '0;
      store_evt <= 1'b0;
    end else begin
      sync1     <= store;
      sync2     <= sync1;
      store_evt <= 1'b0;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        deb       <= sync2;
        deb_cnt   <= '0;
        store_evt <= deb;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    preset_k   = K_ID;
    preset_div = 7'd1;
    preset_inv = 1'b0;
    case (filter)
      3'd1: preset_inv = 1'b1;
      3'd2: begin preset_k = K_BL; preset_div = 7'd16; end
      3'd3: begin preset_k = K_BR; preset_div = 7'd2;  end
      default: ;
    endcase
  end

  always_comb begin
    sum = '0;
    for (int unsigned j = 0; j < 9; j++) sum = sum + 7'(k_custom[j*CW +: CW]);
  end

  // A filter change takes priority over any store event in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      k_custom    <= '0;
      led_store   <= '0;
      led_display <= 1'b0;
      busy        <= 1'b0;
      pend_k      <= K_ID;
      pend_div    <= 7'd1;
      pend_inv    <= 1'b0;
    end else if (filter != 3'd4) begin
      state       <= IDLE;
      idx         <= '0;
      k_custom    <= '0;
      led_store   <= '0;
      led_display <= 1'b0;
      busy        <= 1'b0;
      if (state == IDLE) begin
        pend_k   <= preset_k;
        pend_div <= preset_div;
        pend_inv <= preset_inv;
      end
    end else begin
      case (state)
        IDLE: begin
          state     <= ENTRY;
          idx       <= '0;
          k_custom  <= '0;
          led_store <= '0;
          busy      <= 1'b1;
          pend_k    <= K_ID;
          pend_div  <= 7'd1;
          pend_inv  <= 1'b0;
        end
        ENTRY: begin
          if (store_evt) begin
            k_custom[idx*CW +: CW] <= k_in;
            led_store[idx]         <= 1'b1;
            if (idx == 4'd8) begin
              state       <= DONE;
              busy        <= 1'b0;
              led_display <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          pend_k   <= k_custom;
          pend_inv <= 1'b0;
          pend_div <= (div && sum != '0) ? sum : 7'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_flat <= K_ID;
      divide <= 7'd1;
      invert <= 1'b0;
    end else if (frame_start) begin
      k_flat <= pend_k;
      divide <= pend_div;
      invert <= pend_inv;
    end
  end

endmodule

// File: tb/tb_kernel_config_ctrl.sv
// Directed self-checking bench for kernel_config_ctrl (short debounce).
module tb_kernel_config_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  filter;
  logic [2:0]  k_in;
  logic        store;
  logic        div;
  logic        frame_start;
  logic [26:0] k_flat;
  logic [6:0]  divide;
  logic        invert;
  logic [8:0]  led_store;
  logic        led_display;
  logic        busy;

  int checks = 0;
  int errors = 0;

  kernel_config_ctrl #(.DEB_CYCLES(4), .CW(3)) dut (
    .clk(clk), .rst(rst), .filter(filter), .k_in(k_in), .store(store),
    .div(div), .frame_start(frame_start), .k_flat(k_flat), .divide(divide),
    .invert(invert), .led_store(led_store), .led_display(led_display), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [26:0] k;
    logic [6:0]  d;
    logic        inv;
  } vec_t;

  vec_t tbl[7];

  // Nibble j holds coefficient kj.
  function automatic logic [26:0] kexp(input logic [35:0] nib);
    logic [26:0] r;
    r = '0;
    for (int j = 0; j < 9; j++) r[j*3 +: 3] = nib[j*4 +: 3];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
  endtask

  task automatic press(input logic [2:0] k);
    k_in  = k;
    store = 1'b1;
    cyc(10);
    store = 1'b0;
    cyc(8);
  endtask

  task automatic check_active(input string name, input logic [26:0] k, input logic [6:0] d, input logic inv);
    check({name, "_k"}, 64'(k_flat), 64'(k));
    check({name, "_div"}, 64'(divide), 64'(d));
    check({name, "_inv"}, 64'(invert), 64'(inv));
  endtask

  initial begin
    logic [26:0] k_id, k_bl, k_br, k_cu;
    k_id = kexp(36'h000010000);
    k_bl = kexp(36'h121242121);
    k_br = kexp(36'h000030000);
    k_cu = kexp(36'h117654321);

    tbl[0] = '{"id",   3'd0, k_id, 7'd1,  1'b0};
    tbl[1] = '{"inv",  3'd1, k_id, 7'd1,  1'b1};
    tbl[2] = '{"blur", 3'd2, k_bl, 7'd16, 1'b0};
    tbl[3] = '{"brt",  3'd3, k_br, 7'd2,  1'b0};
    tbl[4] = '{"f5",   3'd5, k_id, 7'd1,  1'b0};
    tbl[5] = '{"f6",   3'd6, k_id, 7'd1,  1'b0};
    tbl[6] = '{"f7",   3'd7, k_id, 7'd1,  1'b0};

    rst = 1'b0; filter = 3'd0; k_in = '0; store = 1'b0; div = 1'b0; frame_start = 1'b0;
    cyc(2);
    check_active("rst", k_id, 7'd1, 1'b0);
    check("rst_leds", 64'({led_store, led_display, busy}), 64'd0);
    rst = 1'b1;
    cyc(2);
    frame();
    check_active("id_first", k_id, 7'd1, 1'b0);
    check("id_leds", 64'({led_store, led_display, busy}), 64'd0);

    filter = 3'd2;
    cyc(1000);
    check_active("blur_hold", k_id, 7'd1, 1'b0);
    frame();
    check_active("blur_apply", k_bl, 7'd16, 1'b0);

    for (int i = 0; i < 7; i++) begin
      filter = tbl[i].f;
      cyc(2);
      frame();
      check_active(tbl[i].name, tbl[i].k, tbl[i].d, tbl[i].inv);
    end

    // Pending change coincident with frame_start copies the old pending value.
    filter = 3'd2;
    frame();
    check_active("coinc_old", k_id, 7'd1, 1'b0);
    cyc(1);
    frame();
    check_active("coinc_new", k_bl, 7'd16, 1'b0);

    filter = 3'd4;
    div    = 1'b1;
    cyc(2);
    check("entry_busy", 64'(busy), 64'd1);
    check("entry_leds", 64'(led_store), 64'd0);

    store = 1'b1;
    cyc(2);
    store = 1'b0;
    cyc(20);
    check("glitch", 64'(led_store), 64'd0);

    k_in  = 3'd1;
    store = 1'b1;
    cyc(10);
    store = 1'b0;
    cyc(6);
    check("lat_early", 64'(led_store), 64'd0);
    cyc(1);
    check("lat_edge", 64'(led_store), 64'h001);
    cyc(10);
    check("one_evt", 64'(led_store), 64'h001);

    press(3'd2); press(3'd3); press(3'd4); press(3'd5);
    press(3'd6); press(3'd7); press(3'd1); press(3'd1);
    check("cu_ledstore", 64'(led_store), 64'h1FF);
    check("cu_leddisp", 64'(led_display), 64'd1);
    check("cu_busy", 64'(busy), 64'd0);
    check_active("cu_hold", k_bl, 7'd16, 1'b0);
    frame();
    check_active("cu_apply", k_cu, 7'd30, 1'b0);
    div = 1'b0;
    cyc(2);
    frame();
    check_active("cu_nodiv", k_cu, 7'd1, 1'b0);

    filter = 3'd0;
    cyc(2);
    filter = 3'd4;
    div    = 1'b1;
    cyc(2);
    for (int i = 0; i < 9; i++) press(3'd0);
    frame();
    check_active("zero", 27'd0, 7'd1, 1'b0);
    press(3'd5);
    check("tenth_leds", 64'(led_store), 64'h1FF);
    cyc(2);
    frame();
    check_active("tenth", 27'd0, 7'd1, 1'b0);

    filter = 3'd0;
    cyc(2);
    filter = 3'd4;
    cyc(2);
    for (int i = 0; i < 4; i++) press(3'd2);
    check("abort_pre", 64'({led_store, busy}), 64'({9'h00F, 1'b1}));
    filter = 3'd3;
    cyc(1);
    check("abort_leds", 64'({led_store, led_display, busy}), 64'd0);
    cyc(1);
    frame();
    check_active("abort_brt", k_br, 7'd2, 1'b0);

    filter = 3'd4;
    cyc(2);
    press(3'd5); press(3'd6);
    check("rst_pre", 64'(led_store), 64'h003);
    rst = 1'b0;
    #1;
    check_active("rst_mid", k_id, 7'd1, 1'b0);
    check("rst_mid_leds", 64'({led_store, led_display, busy}), 64'd0);
    cyc(1);
    rst = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_config_ctrl.md
Name: kernel_config_ctrl

Overview:
Configuration controller for the 3x3 convolution datapath. It decodes the filter-select switches into a kernel, divide value and invert flag. It also sequences user entry of the nine custom kernel coefficients using a debounced store button. Results go into a pending register set, which is copied to the outputs only on a frame-start pulse, so the VGA pipeline never shows a kernel change mid-frame.

Parameters:
DEB_CYCLES, 50000, consecutive stable cycles needed to accept a new button level (2 ms at 25 MHz).
CW, 3, width of each kernel coefficient.

Ports:
clk  in  1  pixel clock (25 MHz VGA clock domain)
rst  in  1  reset; asynchronous, active-low
filter  in  3  0=identity, 1=invert, 2=blur, 3=brighten, 4=custom; 5-7 decode as identity
k_in  in  CW  custom coefficient switches
store  in  1  raw push button, active-high while pressed; asynchronous to clk
div  in  1  custom mode: 1 = divide by coefficient sum, 0 = divide by 1
frame_start  in  1  one-cycle pulse at start of vertical blanking
k_flat  out  9*CW  active kernel; k0 in [CW-1:0], k8 in the top bits; row-major, k4 is the centre
divide  out  7  active divisor, never 0
invert  out  1  active invert flag
led_store  out  9  bit i set once coefficient i is stored
led_display  out  1  custom kernel fully entered
busy  out  1  high while in ENTRY

Behaviour:
Reset (async, rst=0):
- Active and pending kernel = identity (k4=1, all other coefficients 0); divide=1; invert=0.
- led_store=0, led_display=0, busy=0.
- State=IDLE, index i=0, k_custom cleared.
- Synchroniser flops, debounced level and debounce counter all cleared.
- Reset mid-entry discards all entered coefficients.

Button conditioning:
- store passes through a 2-flop synchroniser.
- The counter increments while the synchronised level differs from the debounced level, and clears when they match.
- When the counter reaches DEB_CYCLES-1, the debounced level flips and the counter clears.
- store_evt is a one-cycle pulse on the debounced 1->0 transition (release).
- Latency from raw release to store_evt is DEB_CYCLES+2 cycles (2 synchroniser cycles, then DEB_CYCLES debounce cycles).

Preset decode (pending set, updated every cycle in IDLE):
- ID: identity, divide 1, invert 0.
- INV: identity, divide 1, invert 1.
- BL: 1 2 1 / 2 4 2 / 1 2 1, divide 16, invert 0.
- BR: k4=3, all others 0, divide 2, invert 0.

FSM (states IDLE, ENTRY, DONE):
- Any state with filter != 4: go to IDLE. Clear k_custom, led_store and led_display; set i=0.
- IDLE with filter == 4: go to ENTRY. Set i=0, clear k_custom and led_store; pending = identity, divide 1, invert 0.
- ENTRY, on store_evt:
  - k_custom[i] <= k_in and led_store[i] <= 1.
  - If i==8, go to DONE; otherwise i <= i+1.
  - Pending stays identity throughout ENTRY.
- DONE:
  - Pending kernel = k_custom; invert 0; led_display=1.
  - Pending divide = div ? sum(k_custom) : 1, re-evaluated every cycle.
  - If the sum is 0, divide=1. Maximum sum is 9*7=63, which fits 7 bits.
  - store_evt is ignored.
- store_evt in IDLE is ignored.
- If a filter change and store_evt occur in the same cycle, the filter change wins and no coefficient is written.

Frame-synchronous update:
- On frame_start, active outputs <= pending registers, visible in the next cycle.
- If pending changes in the same cycle as frame_start, the pre-change pending value is copied. The new value applies at the following frame_start.
- Outputs never change except on a frame_start or on reset.
- led_store, led_display and busy are not frame-synchronised; they update immediately.

Test Plan:
- Reset, then filter=0 and one frame_start -> k_flat has only k4=1, divide=1, invert=0, all LEDs 0.
- filter=2 with no frame_start for 1000 cycles -> outputs stay identity. After frame_start, the next cycle shows k=1,2,1,2,4,2,1,2,1 and divide=16.
- DEB_CYCLES=4; a store glitch high for 2 cycles -> no store_evt. A clean press of 10 cycles then release -> exactly one store_evt, 6 cycles after release, and led_store=9'b000000001.
- filter=4; enter k_in=1..7,1,1 over nine presses with div=1, then frame_start -> k_flat matches the entered values, divide=30, led_display=1, busy=0. Toggle div=0 and send frame_start -> divide=1.
- filter=4 with all nine entries 0 and div=1 -> divide=1. A tenth press in DONE -> no change.
- Abort and reset cases:
  - In ENTRY after 4 stores, set filter=3 -> IDLE, led_store=0. After frame_start, k4=3 and divide=2.
  - Assert rst during ENTRY -> all outputs return to reset values immediately.
